// File: rtl/outagu_pkg.sv
// Shared MVU write-back package: default widths, latched transfer config and FSM states.
package outagu_pkg;

    localparam int unsigned BPREC    = 6;
    localparam int unsigned BDBANKA  = 15;
    localparam int unsigned BDBANKW  = 64;
    localparam int unsigned BWLENGTH = 8;
    localparam int unsigned NLEVELS  = 4;

    typedef struct packed {
        logic [BPREC-1:0]                   prec;
        logic [NLEVELS-1:0][BDBANKA-1:0]    stride;
        logic [NLEVELS-1:0][BWLENGTH-1:0]   length;
        logic [BDBANKA-1:0]                 base;
    } outagu_cfg_t;

    typedef enum logic {
        StIdle,
        StRun
    } outagu_state_e;

endpackage

// File: rtl/outagu_nestcnt.sv
// Four-level nested loop counter; reports the element-base increment of the next step and
// whether every level has reached its last index.
module outagu_nestcnt
    import outagu_pkg::*;
(
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                i_clear,
    input  logic                                i_step,
    input  logic [NLEVELS-1:0][BWLENGTH-1:0]    i_length,
    input  logic [NLEVELS-1:0][BDBANKA-1:0]     i_stride,
    output logic [BDBANKA-1:0]                  o_incr,
    output logic                                o_last
);

    logic [NLEVELS-1:0][BWLENGTH-1:0] r_cnt;
    logic [NLEVELS-1:0]               w_more;
    logic [NLEVELS-1:0]               w_sel;
    logic [NLEVELS-1:0]               w_low;

    always_comb begin
        for (int k = 0; k < NLEVELS; k++) begin
            w_more[k] = r_cnt[k] < i_length[k];
        end
    end

    // Lowest level that still has iterations left wins; scan downward so it overrides.
    always_comb begin
        w_sel  = '0;
        o_incr = '0;
        for (int k = NLEVELS - 1; k >= 0; k--) begin
            if (w_more[k]) begin
                w_sel    = '0;
                w_sel[k] = 1'b1;
                o_incr   = i_stride[k];
            end
        end
    end

    assign w_low  = w_sel - NLEVELS'(1);
    assign o_last = ~|w_more;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_step && !o_last) begin
            for (int k = 0; k < NLEVELS; k++) begin
                if (w_sel[k]) begin
                    r_cnt[k] <= r_cnt[k] + BWLENGTH'(1);
                end else if (w_low[k]) begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/outagu.sv
// MVU output address generation unit: bit-serial write-back with 4-level strided addressing.
// Optional OUTAGU_PERF_CNT_EN adds saturating granted-write and stall counters.
module outagu
    import outagu_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [BPREC-1:0]      oprecision,
    input  logic [BDBANKA-1:0]    ostride0,
    input  logic [BDBANKA-1:0]    ostride1,
    input  logic [BDBANKA-1:0]    ostride2,
    input  logic [BDBANKA-1:0]    ostride3,
    input  logic [BWLENGTH-1:0]   olength0,
    input  logic [BWLENGTH-1:0]   olength1,
    input  logic [BWLENGTH-1:0]   olength2,
    input  logic [BWLENGTH-1:0]   olength3,
    input  logic [BDBANKA-1:0]    obaseaddr,
    input  logic                  in_valid,
    input  logic [BDBANKW-1:0]    in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [BDBANKA-1:0]    mem_addr,
    output logic [BDBANKW-1:0]    mem_wdata,
    input  logic                  mem_grant,
    output logic                  omsb,
    output logic                  busy,
    output logic                  done
`ifdef OUTAGU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_writes,
    output logic [31:0]           perf_stalls
`endif
);

    outagu_state_e        r_state;
    outagu_cfg_t          r_cfg;
    logic [BPREC-1:0]     r_bit;
    logic [BDBANKA-1:0]   r_elem;
    logic                 r_final;
    logic                 r_we;
    logic [BDBANKA-1:0]   r_addr;
    logic [BDBANKW-1:0]   r_wdata;
    logic                 r_msb;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_bit_last;
    logic                 w_step;
    logic                 w_start;
    logic [BDBANKA-1:0]   w_incr;
    logic                 w_last;

    assign busy      = (r_state == StRun);
    assign in_ready  = busy & (~r_we | mem_grant) & ~r_final;
    assign w_accept  = in_valid & in_ready;
    assign w_bit_last = (r_bit == r_cfg.prec - BPREC'(1));
    assign w_step    = w_accept & w_bit_last;
    assign w_start   = start & (r_state == StIdle) & (oprecision != '0);

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign omsb      = r_msb;
    assign done      = r_done;

    outagu_nestcnt u_nestcnt (
        .clk      (clk),
        .clr      (clr),
        .i_clear  (w_start),
        .i_step   (w_step),
        .i_length (r_cfg.length),
        .i_stride (r_cfg.stride),
        .o_incr   (w_incr),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= StIdle;
            r_cfg   <= '0;
            r_bit   <= '0;
            r_elem  <= '0;
            r_final <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_msb   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_cfg.prec   <= oprecision;
                        r_cfg.stride <= {ostride3, ostride2, ostride1, ostride0};
                        r_cfg.length <= {olength3, olength2, olength1, olength0};
                        r_cfg.base   <= obaseaddr;
                        r_bit        <= '0;
                        r_elem       <= '0;
                        r_final      <= 1'b0;
                        r_state      <= StRun;
                    end
                end
                StRun: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_cfg.base + r_elem + BDBANKA'(r_bit);
                        r_wdata <= in_data;
                        r_msb   <= (r_bit == '0);
                        if (w_bit_last) begin
                            r_bit <= '0;
                            if (w_last) begin
                                r_final <= 1'b1;
                            end else begin
                                r_elem <= r_elem + w_incr;
                            end
                        end else begin
                            r_bit <= r_bit + BPREC'(1);
                        end
                    end else if (mem_grant) begin
                        r_we <= 1'b0;
                    end
                    // No beat can be accepted once final is pending, so r_we drops here too.
                    if (r_we && mem_grant && r_final) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                        r_final <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef OUTAGU_PERF_CNT_EN
    logic [31:0] r_perf_writes;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_perf_writes <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_we && mem_grant && !(&r_perf_writes)) begin
                r_perf_writes <= r_perf_writes + 32'd1;
            end
            if (r_we && !mem_grant && !(&r_perf_stalls)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_writes = r_perf_writes;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_outagu.sv
// Self-checking bench for outagu: table vectors, random configs and handshake corner cases.
module tb_outagu;
    import outagu_pkg::*;

    logic                 clk = 1'b0;
    logic                 clr;
    logic                 start;
    logic [BPREC-1:0]     oprecision;
    logic [BDBANKA-1:0]   ostride0, ostride1, ostride2, ostride3;
    logic [BWLENGTH-1:0]  olength0, olength1, olength2, olength3;
    logic [BDBANKA-1:0]   obaseaddr;
    logic                 in_valid;
    logic [BDBANKW-1:0]   in_data;
    logic                 in_ready;
    logic                 mem_we;
    logic [BDBANKA-1:0]   mem_addr;
    logic [BDBANKW-1:0]   mem_wdata;
    logic                 mem_grant;
    logic                 omsb;
    logic                 busy;
    logic                 done;
`ifdef OUTAGU_PERF_CNT_EN
    logic [31:0]          perf_writes;
    logic [31:0]          perf_stalls;
`endif

    always #5 clk = ~clk;

    outagu dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .oprecision (oprecision),
        .ostride0   (ostride0),
        .ostride1   (ostride1),
        .ostride2   (ostride2),
        .ostride3   (ostride3),
        .olength0   (olength0),
        .olength1   (olength1),
        .olength2   (olength2),
        .olength3   (olength3),
        .obaseaddr  (obaseaddr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_grant  (mem_grant),
        .omsb       (omsb),
        .busy       (busy),
        .done       (done)
`ifdef OUTAGU_PERF_CNT_EN
        ,
        .perf_writes (perf_writes),
        .perf_stalls (perf_stalls)
`endif
    );

    typedef struct packed {
        logic [5:0]        p;
        logic [3:0][7:0]   len;
        logic [3:0][14:0]  str;
        logic [14:0]       base;
        logic [1:0]        mode;     // 0: always valid/grant, 1: random, 2: 3-cycle stall on write 1
        int unsigned       exp_beats;
        logic [14:0]       exp_last;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [14:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int p, input int l0, input int l1, input int l2,
                                input int l3, input int s0, input int s1, input int s2,
                                input int s3, input int base, input int mode, input int beats,
                                input int last);
        vec_t v;
        v.p = 6'(p);
        v.len = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
        v.str = {15'(s3), 15'(s2), 15'(s1), 15'(s0)};
        v.base = 15'(base);
        v.mode = 2'(mode);
        v.exp_beats = beats;
        v.exp_last = 15'(last);
        return v;
    endfunction

    // Address of every beat from closed-form advance counts per loop level.
    task automatic build_model(input vec_t v);
        longint unsigned l0, l1, l2, l3, a0, a1, a2, a3, e;
        l0 = v.len[0]; l1 = v.len[1]; l2 = v.len[2]; l3 = v.len[3];
        exp_q.delete();
        for (longint unsigned i3 = 0; i3 <= l3; i3++)
            for (longint unsigned i2 = 0; i2 <= l2; i2++)
                for (longint unsigned i1 = 0; i1 <= l1; i1++)
                    for (longint unsigned i0 = 0; i0 <= l0; i0++)
                        for (longint unsigned b = 0; b < v.p; b++) begin
                            a3 = i3;
                            a2 = i2 + l2 * i3;
                            a1 = i1 + l1 * (i2 + (l2 + 1) * i3);
                            a0 = i0 + l0 * (i1 + (l1 + 1) * (i2 + (l2 + 1) * i3));
                            e = v.base + a0 * v.str[0] + a1 * v.str[1] + a2 * v.str[2]
                                + a3 * v.str[3] + b;
                            exp_q.push_back(e[14:0]);
                        end
    endtask

    task automatic set_cfg(input vec_t v);
        oprecision = v.p;
        olength0 = v.len[0]; olength1 = v.len[1]; olength2 = v.len[2]; olength3 = v.len[3];
        ostride0 = v.str[0]; ostride1 = v.str[1]; ostride2 = v.str[2]; ostride3 = v.str[3];
        obaseaddr = v.base;
    endtask

    task automatic scramble_cfg();
        oprecision = 6'($urandom);
        olength0 = 8'($urandom); olength1 = 8'($urandom);
        olength2 = 8'($urandom); olength3 = 8'($urandom);
        ostride0 = 15'($urandom); ostride1 = 15'($urandom);
        ostride2 = 15'($urandom); ostride3 = 15'($urandom);
        obaseaddr = 15'($urandom);
    endtask

    // Runs one transfer; with chained=1 the caller has already raised start.
    // Returns at the done cycle (negedge + 1), leaving time to launch the next start.
    task automatic run_xfer(input vec_t v, input bit chained);
        int          wr, first_acc, last_acc, stall_cnt;
        bit          hold, exp_done, fin;
        logic [14:0] h_addr, last_addr;
        logic [63:0] h_data;
        logic [63:0] data_q[$];
        build_model(v);
        wr = 0; first_acc = -1; last_acc = 0; stall_cnt = 0;
        hold = 0; exp_done = 0; fin = 0; last_addr = '0; h_addr = '0; h_data = '0;
        if (!chained) begin
            @(negedge clk);
            set_cfg(v);
            start = 1'b1;
            in_valid = 1'b0;
            mem_grant = 1'b1;
        end
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            scramble_cfg();
            if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
            in_valid = (v.mode == 2'd1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data = {$urandom, $urandom};
            case (v.mode)
                2'd1:    mem_grant = ($urandom_range(0, 2) != 0);
                2'd2:    mem_grant = !(wr == 1 && stall_cnt < 3);
                default: mem_grant = 1'b1;
            endcase
            #1;
            if (cyc == 0) chk("busy_after_start", 64'(busy), 64'd1);
            chk("done", 64'(done), 64'(exp_done));
            if (exp_done) begin
                chk("busy_at_done", 64'(busy), 64'd0);
                fin = 1;
            end
            exp_done = 0;
            if (hold) begin
                chk("stall_we", 64'(mem_we), 64'd1);
                chk("stall_addr", 64'(mem_addr), 64'(h_addr));
                chk("stall_data", mem_wdata, h_data);
            end
            if (mem_we && !mem_grant) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                hold = 1; h_addr = mem_addr; h_data = mem_wdata; stall_cnt++;
            end else begin
                hold = 0;
            end
            if (in_valid && in_ready) begin
                data_q.push_back(in_data);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (mem_we && mem_grant) begin
                if (wr < exp_q.size() && wr < data_q.size()) begin
                    chk("addr", 64'(mem_addr), 64'(exp_q[wr]));
                    chk("wdata", mem_wdata, data_q[wr]);
                    chk("omsb", 64'(omsb), 64'((wr % int'(v.p)) == 0));
                end else begin
                    chk("extra_write", 64'(wr), 64'(exp_q.size()));
                end
                last_addr = mem_addr;
                wr++;
                if (wr == exp_q.size()) exp_done = 1;
            end
        end
        chk("finished", 64'(fin), 64'd1);
        chk("writes", 64'(wr), 64'(v.exp_beats));
        chk("accepted", 64'(data_q.size()), 64'(v.exp_beats));
        chk("last_addr", 64'(last_addr), 64'(v.exp_last));
        if (v.mode == 2'd0) chk("no_bubbles", 64'(last_acc - first_acc + 1), 64'(v.exp_beats));
    endtask

    vec_t vecs[6];
    vec_t rv;
    int   acc;

    initial begin
        vecs[0] = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 100, 0, 2, 101);
        vecs[1] = mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 3);
        vecs[2] = mk(2, 1, 1, 0, 0, 2, 6, 0, 0, 0, 0, 8, 11);
        vecs[3] = mk(1, 1, 0, 0, 0, 'h7FFF, 0, 0, 0, 0, 0, 2, 'h7FFF);
        vecs[4] = mk(3, 2, 1, 1, 1, 5, 'h7FFD, 40, 'h7000, 'h7FF0, 1, 72, 'h7086);
        vecs[5] = mk(4, 1, 2, 0, 0, 4, 16, 0, 0, 'h1234, 1, 24, 'h1263);

        clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_grant = 1'b0;
        set_cfg(vecs[0]);
        #1;
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_omsb", 64'(omsb), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        clr = 1'b0;

        // start with zero precision is ignored
        @(negedge clk);
        set_cfg(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 0));
        start = 1'b1; in_valid = 1'b1; mem_grant = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("p0_busy", 64'(busy), 64'd0);
        chk("p0_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("p0_we", 64'(mem_we), 64'd0);
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], 1'b0);

        // grant held low for 3 cycles on the second write; counters start from clr
        @(negedge clk);
        clr = 1'b1;
        #1;
        clr = 1'b0;
        run_xfer(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 100, 2, 2, 101), 1'b0);
`ifdef OUTAGU_PERF_CNT_EN
        chk("perf_writes", 64'(perf_writes), 64'd2);
        chk("perf_stalls", 64'(perf_stalls), 64'd3);
`endif
        // start in the done cycle is accepted
        rv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 7);
        set_cfg(rv);
        start = 1'b1;
        in_valid = 1'b0;
        run_xfer(rv, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rv = mk($urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 32767),
                    $urandom_range(0, 32767), $urandom_range(0, 32767),
                    $urandom_range(0, 32767), $urandom_range(0, 32767), i % 2, 0, 0);
            build_model(rv);
            rv.exp_beats = exp_q.size();
            rv.exp_last = exp_q[$];
            run_xfer(rv, 1'b0);
        end

        // clr while the third of eight beats is on the write port
        @(negedge clk);
        set_cfg(mk(2, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 8, 7));
        start = 1'b1; in_valid = 1'b0; mem_grant = 1'b1;
        acc = 0;
        for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            #1;
            if (in_valid && in_ready) acc++;
        end
        chk("clr_accepts", 64'(acc), 64'd3);
        @(posedge clk);
        #1;
        chk("clr_pre_we", 64'(mem_we), 64'd1);
        chk("clr_pre_addr", 64'(mem_addr), 64'd2);
        clr = 1'b1;
        #1;
        chk("clr_we", 64'(mem_we), 64'd0);
        chk("clr_addr", 64'(mem_addr), 64'd0);
        chk("clr_wdata", mem_wdata, 64'd0);
        chk("clr_omsb", 64'(omsb), 64'd0);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("post_clr_in_ready", 64'(in_ready), 64'd0);
            chk("post_clr_we", 64'(mem_we), 64'd0);
            chk("post_clr_busy", 64'(busy), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/outagu.md
# outagu

Output address generation unit for the MVU write-back path. It accepts bit-serial result words from the output quantizer/serializer and generates the data-memory write address for each one. Addressing uses a 4-level nested stride pattern, and each element occupies `oprecision` consecutive words with the MSB first. It is the write-side counterpart of the input/weight read AGUs. It sits between the quantizer output stream and the data-memory write port.

## Interface
- `BPREC`, 6: bitwidth of precision fields.
- `BDBANKA`, 15: bitwidth of data-memory address.
- `BDBANKW`, 64: data-memory word width.
- `BWLENGTH`, 8: bitwidth of loop length fields.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `clr`, in, 1: asynchronous active-high reset.
- `start`, in, 1: one-cycle pulse. Latches the configuration and begins a transfer.
- `oprecision`, in, `BPREC`: output precision P, in words per element.
- `ostride0..3`, in, `BDBANKA` each: element-base jumps for loop levels 0..3. Two's complement, added modulo 2^`BDBANKA`.
- `olength0..3`, in, `BWLENGTH` each: last index of loop levels 0..3. A level runs `olengthN`+1 iterations.
- `obaseaddr`, in, `BDBANKA`: transfer base address.
- `in_valid`, in, 1: result word valid.
- `in_data`, in, `BDBANKW`: result bit-plane word.
- `in_ready`, out, 1: result word accepted when `in_valid & in_ready`.
- `mem_we`, out, 1: write request.
- `mem_addr`, out, `BDBANKA`: write address.
- `mem_wdata`, out, `BDBANKW`: write data.
- `mem_grant`, in, 1: write port accepts the request this cycle.
- `omsb`, out, 1: the current `mem_addr` holds an element MSB (bit offset 0).
- `busy`, out, 1: a transfer is in progress.
- `done`, out, 1: one-cycle pulse after the final write is granted.

## Operation
- States:
  - IDLE: `busy`=0, `in_ready`=0.
  - RUN: `busy`=1.
- IDLE→RUN on `start` when P≠0. All configuration is latched at that point. `start` with P=0 is ignored.
- `start` while in RUN is ignored. Configuration inputs are don't-care after latching.
- Internal state:
  - bit offset b, 0..P-1.
  - loop counters c0..c3.
  - element base register E, reset to 0 at start.
- Address of each accepted beat: `obaseaddr + E + b`, truncated to `BDBANKA` bits.
- Per accepted beat: if b<P-1 then b++. Otherwise b=0 and the element advances as follows:
  - if c0<l0: c0++, E+=ostride0;
  - else c0=0, and if c1<l1: c1++, E+=ostride1;
  - else c1=0, and if c2<l2: c2++, E+=ostride2;
  - else c2=0, and if c3<l3: c3++, E+=ostride3;
  - else this is the final beat.
- Total beats per transfer: P·(l0+1)(l1+1)(l2+1)(l3+1).
- Final beat: no further beats are accepted. RUN→IDLE when its write is granted.
- `clr` at any time: return to IDLE and zero all state. An in-flight write is dropped.

## Timing
- Reset values: `mem_we`, `mem_addr`, `mem_wdata`, `omsb`, `busy`, `done`, `in_ready` are all 0.
- Latency: a beat accepted at cycle t appears on `mem_we`/`mem_addr`/`mem_wdata`/`omsb` at t+1. All outputs are registered.
- `in_ready = busy & (~mem_we | mem_grant) & ~final_pending`.
- Full throughput (one beat per cycle) while `mem_grant`=1.
- While `mem_we & ~mem_grant`, write outputs hold stable and no beat is accepted.
- `mem_we` drops the cycle after a grant unless a new beat was accepted in the granting cycle.
- `done`=1 and `busy`=0 on the cycle after the final write's grant.
- `start` arriving in the same cycle as `done` is accepted.

## Configuration
- `OUTAGU_PERF_CNT_EN` defined: adds ports `perf_writes` (32-bit out) and `perf_stalls` (32-bit out).
  - `perf_writes` counts granted writes. `perf_stalls` counts cycles with `mem_we & ~mem_grant`.
  - Both saturate at 2^32-1, clear on `clr`, and do not clear on `start`.
- Undefined: the ports and counters are absent.

## Structure
- Shared MVU package holds:
  - default widths `BPREC`, `BDBANKA`, `BDBANKW`, `BWLENGTH`;
  - a latched-config struct (P, strides, lengths, base).
- Sub-module `outagu_nestcnt`: the 4-level counter with stride select.
  - Inputs: step, lengths, strides.
  - Outputs: E increment value and last flag.
- `outagu` instantiates it and adds the bit offset, handshake and output registers.

## Test plan
- P=2, all lengths 0, base 100; two beats → writes to 100, 101 with `omsb` 1,0. `done` pulses one cycle after the second grant.
- P=1, l0=3, ostride0=1, base 0 → writes 0,1,2,3 on consecutive cycles with no bubbles.
- P=2, l0=1, l1=1, ostride0=2, ostride1=6, base 0 → writes 0,1,2,3,8,9,10,11, then `done`.
- `mem_grant` held low 3 cycles on the second write → `mem_addr`/`mem_wdata` stable for 3 cycles and `in_ready` low. All beats are written exactly once, in order.
- Wrap-around: P=1, l0=1, ostride0=0x7FFF, base 0 → writes 0, 0x7FFF. Also: `start` with P=0 → stays IDLE.
- `clr` mid-transfer (beat 3 of 8) → all outputs 0 next edge and further beats refused. Under `OUTAGU_PERF_CNT_EN`, the grant-stall case reads `perf_writes`=2, `perf_stalls`=3.
